// File: rtl/codec_decoder_128bit_pkg.sv
// Shared GF(2^8) arithmetic, FSM encoding and debug view for the network-coding decoder.
// The field polynomial must match the one used by the encoder codecs.
package codec_pkg;

  localparam logic [8:0] GF_POLY   = 9'h11D;
  localparam int         INV_STEPS = 7;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DET   = 3'd1,
    INV   = 3'd2,
    SCALE = 3'd3,
    RUN   = 3'd4,
    SING  = 3'd5
  } state_t;

  typedef struct packed {
    state_t     state;
    logic [7:0] r;
  } dbg_t;

  // Shift-and-add multiply; reducing after every shift keeps the accumulator at 8 bits.
  function automatic logic [7:0] gf_mul8(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = '0;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = sh[7] ? ({sh[6:0], 1'b0} ^ GF_POLY[7:0]) : {sh[6:0], 1'b0};
    end
    return acc;
  endfunction

endpackage

// File: rtl/codec_decoder_128bit_if.sv
// Bus bundle of the decoder: configuration channel, coded input channel, decoded output channel.
// Handshakes: a transfer happens on a rising edge where valid && ready; oValid has no backpressure.
interface codec_decoder_128bit_if;
  import codec_pkg::*;

  logic         iCfgValid;
  logic         oCfgReady;
  logic [7:0]   iA11, iA12, iA21, iA22;
  logic         oCfgDone;
  logic         oSingular;
  logic         iValid;
  logic         oReady;
  logic [127:0] iY1, iY2;
  logic         oValid;
  logic [127:0] oX1, oX2;

  modport master (
    output iCfgValid, iA11, iA12, iA21, iA22, iValid, iY1, iY2,
    input  oCfgReady, oCfgDone, oSingular, oReady, oValid, oX1, oX2
  );

  modport slave (
    input  iCfgValid, iA11, iA12, iA21, iA22, iValid, iY1, iY2,
    output oCfgReady, oCfgDone, oSingular, oReady, oValid, oX1, oX2
  );

endinterface

// File: rtl/codec_decoder_128bit_scalar_mul.sv
// Combinational GF(2^8) scalar times 128-bit word: 16 independent byte lanes.
module gf256_scalar_mul_128
  import codec_pkg::*;
(
  input  logic [7:0]   iScalar,
  input  logic [127:0] iWord,
  output logic [127:0] oWord
);

  for (genvar k = 0; k < 16; k++) begin : gLane
    assign oWord[8*k +: 8] = gf_mul8(iScalar, iWord[8*k +: 8]);
  end

endmodule

// File: rtl/codec_decoder_128bit.sv
// Inverts a 2x2 GF(2^8) coding matrix once per configuration, then decodes coded
// word pairs through a two-stage pipeline (partial products, then XOR combine).
module codec_decoder_128bit
  import codec_pkg::*;
(
  input  logic                   iCLK,
  input  logic                   iRST_n,
  codec_decoder_128bit_if.slave  bus,
  output dbg_t                   oDbg
);

  state_t       state, stateNext;
  logic [7:0]   a11, a12, a21, a22;
  logic [7:0]   s, r, det, sSq;
  logic [7:0]   b11, b12, b21, b22;
  logic [2:0]   invCnt;
  logic         cfgReady, ready, cfgFire, beatFire;
  logic         cfgDoneQ, singularQ;
  logic         v1, validQ;
  logic [127:0] m11, m12, m21, m22;
  logic [127:0] p11, p12, p21, p22;
  logic [127:0] x1Q, x2Q;

  assign det = gf_mul8(a11, a22) ^ gf_mul8(a12, a21);
  assign sSq = gf_mul8(s, s);

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) state <= IDLE;
    else         state <= stateNext;
  end

  // Config only lands in RUN once both pipeline stages are empty, so B never
  // changes under a beat in flight; a pending config also blocks new beats.
  always_comb begin
    stateNext = state;
    cfgReady  = 1'b0;
    ready     = 1'b0;
    case (state)
      IDLE: begin
        cfgReady = 1'b1;
        if (bus.iCfgValid) stateNext = DET;
      end
      DET:   stateNext = (det == 8'h00) ? SING : INV;
      INV:   if (invCnt == 3'(INV_STEPS - 1)) stateNext = SCALE;
      SCALE: stateNext = RUN;
      RUN: begin
        cfgReady = !v1 && !validQ;
        ready    = !bus.iCfgValid;
        if (bus.iCfgValid && cfgReady) stateNext = DET;
      end
      SING: begin
        cfgReady = 1'b1;
        if (bus.iCfgValid) stateNext = DET;
      end
      default: stateNext = IDLE;
    endcase
  end

  assign cfgFire  = bus.iCfgValid && cfgReady;
  assign beatFire = bus.iValid && ready;

  // Square-and-multiply: after 7 steps r = det^(2+4+...+128) = det^254 = det^-1.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      {a11, a12, a21, a22} <= '0;
      {b11, b12, b21, b22} <= '0;
      s         <= '0;
      r         <= '0;
      invCnt    <= '0;
      singularQ <= 1'b0;
      cfgDoneQ  <= 1'b0;
    end else begin
      cfgDoneQ <= (state == SCALE);
      if (cfgFire) begin
        a11       <= bus.iA11;
        a12       <= bus.iA12;
        a21       <= bus.iA21;
        a22       <= bus.iA22;
        singularQ <= 1'b0;
      end
      case (state)
        DET: begin
          s      <= det;
          r      <= 8'h01;
          invCnt <= '0;
          if (det == 8'h00) singularQ <= 1'b1;
        end
        INV: begin
          s      <= sSq;
          r      <= gf_mul8(r, sSq);
          invCnt <= invCnt + 3'd1;
        end
        SCALE: begin
          b11 <= gf_mul8(r, a22);
          b12 <= gf_mul8(r, a12);
          b21 <= gf_mul8(r, a21);
          b22 <= gf_mul8(r, a11);
        end
        default: ;
      endcase
    end
  end

  gf256_scalar_mul_128 uM11 (.iScalar(b11), .iWord(bus.iY1), .oWord(m11));
  gf256_scalar_mul_128 uM12 (.iScalar(b12), .iWord(bus.iY2), .oWord(m12));
  gf256_scalar_mul_128 uM21 (.iScalar(b21), .iWord(bus.iY1), .oWord(m21));
  gf256_scalar_mul_128 uM22 (.iScalar(b22), .iWord(bus.iY2), .oWord(m22));

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      v1     <= 1'b0;
      {p11, p12, p21, p22} <= '0;
      validQ <= 1'b0;
      x1Q    <= '0;
      x2Q    <= '0;
    end else begin
      v1     <= beatFire;
      validQ <= v1;
      if (beatFire) begin
        p11 <= m11;
        p12 <= m12;
        p21 <= m21;
        p22 <= m22;
      end
      if (v1) begin
        x1Q <= p11 ^ p12;
        x2Q <= p21 ^ p22;
      end
    end
  end

  assign bus.oCfgReady = cfgReady;
  assign bus.oReady    = ready;
  assign bus.oCfgDone  = cfgDoneQ;
  assign bus.oSingular = singularQ;
  assign bus.oValid    = validQ;
  assign bus.oX1       = x1Q;
  assign bus.oX2       = x2Q;
  assign oDbg          = {state, r};

endmodule
